pwm_centre_dt: RTL and testbench
================================

// Module: pwm_centre_dt
//
// PURPOSE
// - N-channel centre-aligned (triangle-carrier) PWM with programmable period,
//   double-buffered duty/period, and per-channel complementary outputs with
//   dead-time insertion.
// - Drives half-bridge gate pairs in the motor driver; Sync_Out marks carrier
//   troughs for ADC sampling and control-loop updates.
//
// PARAMETERS
// - N           3       number of channels (phases)
// - W           10      carrier, period and duty width in bits
// - DEAD_W      6       dead-time counter width in bits
// - PERIOD_RST  1023    period value loaded at reset
//
// PORTS
// - Clk       in   1       system clock; all logic on rising edge
// - nReset    in   1       asynchronous, active-low reset
// - Enable    in   1       carrier run/stop
// - Mode      in   1       0: shadow transfer at trough only; 1: at trough and peak
// - Period    in   W       carrier peak value, sampled on Load
// - Dead      in   DEAD_W  dead time in Clk cycles, used live
// - Duty      in   N*W     channel j duty at bits [j*W +: W], sampled on Load
// - Load      in   1       one-cycle strobe: capture Duty and Period into pending
// - Pending   out  1       pending set not yet transferred to active
// - Out_High  out  N       high-side gate drives
// - Out_Low   out  N       low-side gate drives
// - Sync_Out  out  1       one-cycle pulse per carrier period, at trough
//
// BEHAVIOUR
// - Reset: Counter=0, direction up, Active_Duty=0, Active_Period=PERIOD_RST,
//   Pending=0; Out_High=0, Out_Low=0, Sync_Out=0. Reset is async assert, sync
//   release.
// - Carrier counts up 0 to Active_Period, then down to 0, and repeats. Each
//   endpoint is held for exactly one cycle. Period = 2*Active_Period cycles.
// - Active_Period values below 2 are treated as 2.
// - Load: pending regs <= Duty, Period; Pending <= 1. A second Load before
//   transfer overwrites the pending regs (last write wins).
// - Transfer: on the cycle Counter==0 (plus Counter==Active_Period when
//   Mode=1) with Pending=1, active <= pending and Pending <= 0.
// - Load and transfer in the same cycle: the transfer uses the old pending
//   contents. The new Load data becomes pending and Pending stays 1.
// - Raw[j] = (Active_Duty[j] > Counter). It is registered one cycle after the
//   counter. Duty=0 gives always low; Duty > Active_Period gives always high.
// - Dead-time, per channel, one DEAD_W down-counter:
//   - Raw rising edge: Out_Low falls immediately; Out_High rises after Dead
//     cycles.
//   - Raw falling edge: Out_High falls immediately; Out_Low rises after Dead
//     cycles.
//   - If Raw toggles again before the count expires, the count restarts in the
//     new sense. The pulse is swallowed and the pending side never asserts.
//   - Dead=0 gives a plain complementary pair.
// - Invariant: Out_High[j] & Out_Low[j] is never 1, under any input,
//   including changes to Dead mid-count.
// - Latency: Counter to Raw is 1 cycle; Raw to output edge is 1 + Dead cycles.
// - Sync_Out: high for the single cycle after Counter==0.
// - Enable=0:
//   - Counter is forced to 0, direction up.
//   - All Out_High and Out_Low are 0 (bridge off); dead-time counters clear.
//   - Pending is preserved; Load is still accepted. Sync_Out=0.
//   - Transfers may occur while disabled: the counter sits at 0.
// - Enable rising edge: the carrier restarts from 0. Outputs follow Raw through
//   full dead time, with no immediate high-side assertion.
// - Active_Duty is only ever changed at a transfer point, never mid-slope.
//
// STRUCTURE
// - Package pwm_pkg: N/W/DEAD_W defaults, carrier direction enum
//   (DIR_UP, DIR_DOWN), and the period-clamp constant (2).
// - Sub-module dead_time_gen (one per channel, via generate):
//   - ports Clk, nReset, Enable, Raw, Dead, Out_High, Out_Low
//   - owns the edge detect, down-counter and invariant.
// - Top level holds the carrier counter, shadow/active registers and the
//   compare logic.
//
// TESTING
// - Reset/idle: nReset=0, then release, Enable=0.
//   -> all outputs 0, Pending=0, Counter stays 0.
// - Carrier: Period=4, Load, Enable=1.
//   -> Counter 0,1,2,3,4,3,2,1,0. Sync_Out every 8 cycles. Duty=2 gives Raw
//      high for 3 of 8 cycles.
// - Shadow: Load Duty=1 mid-slope, then Load Duty=3 before the trough.
//   -> Raw is unchanged until the trough, then uses 3. Pending 1 then 0.
//   -> Mode=1 repeat: the transfer happens at the peak.
// - Dead time: Dead=3, Duty toggling.
//   -> 3-cycle gap (both low) at every edge.
//   -> Duty=1, Period=10 (Raw width 1) with Dead=3: the high-side pulse is
//      swallowed.
// - Boundaries and overlap:
//   -> Duty=0 gives Out_High never high; Duty=Period+1 gives Out_Low never high.
//   -> Random Duty/Dead/Enable: the assertion Out_High & Out_Low == 0 never
//      fails.
// - Async reset mid-run: drop nReset with outputs active.
//   -> outputs 0 in the same cycle without a clock edge. On release the
//      carrier restarts from 0 with Active_Period=PERIOD_RST.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the centre-aligned dead-time PWM.
package pwm_pkg;

  localparam int unsigned DefN      = 3;
  localparam int unsigned DefW      = 10;
  localparam int unsigned DefDeadW  = 6;
  localparam int unsigned PeriodMin = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/dead_time_gen.sv
// Per-channel complementary driver: turns one raw PWM bit into a high/low gate
// pair with a programmable gap where both sides are off.
module dead_time_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD_W = DefDeadW
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Enable,
  input  logic              Raw,
  input  logic [DEAD_W-1:0] Dead,
  output logic              Out_High,
  output logic              Out_Low
);

  logic              raw_prev_q;
  logic              en_q;
  logic              hi_q, hi_d;
  logic              lo_q, lo_d;
  logic [DEAD_W-1:0] cnt_q, cnt_d;

  // Every change (and enable start) drops both sides before the new side may
  // assert, so the gate pair can never overlap whatever Dead does.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (!Enable) begin
      hi_d  = 1'b0;
      lo_d  = 1'b0;
      cnt_d = '0;
    end else if ((Raw != raw_prev_q) || !en_q) begin
      if (Dead == '0) begin
        hi_d  = Raw;
        lo_d  = ~Raw;
        cnt_d = '0;
      end else begin
        hi_d  = 1'b0;
        lo_d  = 1'b0;
        cnt_d = Dead;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DEAD_W'(1);
      if (cnt_q == DEAD_W'(1)) begin
        hi_d = Raw;
        lo_d = ~Raw;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      raw_prev_q <= 1'b0;
      en_q       <= 1'b0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      raw_prev_q <= Raw;
      en_q       <= Enable;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Out_High = hi_q;
  assign Out_Low  = lo_q;

endmodule

// File: rtl/pwm_centre_dt.sv
// N-channel triangle-carrier PWM with double-buffered duty/period and
// per-channel dead-time insertion.
module pwm_centre_dt
  import pwm_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned W          = DefW,
  parameter int unsigned DEAD_W     = DefDeadW,
  parameter int unsigned PERIOD_RST = 1023
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Enable,
  input  logic              Mode,
  input  logic [W-1:0]      Period,
  input  logic [DEAD_W-1:0] Dead,
  input  logic [N*W-1:0]    Duty,
  input  logic              Load,
  output logic              Pending,
  output logic [N-1:0]      Out_High,
  output logic [N-1:0]      Out_Low,
  output logic              Sync_Out
);

  logic [W-1:0]   cnt_q, cnt_d;
  dir_e           dir_q, dir_d;
  logic [W-1:0]   act_per_q, act_per_d;
  logic [W-1:0]   pend_per_q, pend_per_d;
  logic [N*W-1:0] act_duty_q, act_duty_d;
  logic [N*W-1:0] pend_duty_q, pend_duty_d;
  logic           pend_q, pend_d;
  logic           sync_q, sync_d;
  logic [N-1:0]   raw_q, raw_d;
  logic [W-1:0]   per_eff;
  logic           transfer;

  always_comb begin
    per_eff  = (act_per_q < W'(PeriodMin)) ? W'(PeriodMin) : act_per_q;
    transfer = pend_q && ((cnt_q == '0) || (Mode && (cnt_q == per_eff)));

    // A Load coinciding with a transfer still hands over the old pending set.
    act_per_d   = transfer ? pend_per_q : act_per_q;
    act_duty_d  = transfer ? pend_duty_q : act_duty_q;
    pend_per_d  = Load ? Period : pend_per_q;
    pend_duty_d = Load ? Duty : pend_duty_q;
    pend_d      = Load | (pend_q & ~transfer);

    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!Enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_eff) begin
        cnt_d = cnt_q - W'(1);
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d = W'(1);
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end

    for (int j = 0; j < int'(N); j++) begin
      raw_d[j] = act_duty_q[j*W +: W] > cnt_q;
    end
    sync_d = Enable && (cnt_q == '0);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      act_per_q   <= W'(PERIOD_RST);
      pend_per_q  <= '0;
      act_duty_q  <= '0;
      pend_duty_q <= '0;
      pend_q      <= 1'b0;
      sync_q      <= 1'b0;
      raw_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      act_per_q   <= act_per_d;
      pend_per_q  <= pend_per_d;
      act_duty_q  <= act_duty_d;
      pend_duty_q <= pend_duty_d;
      pend_q      <= pend_d;
      sync_q      <= sync_d;
      raw_q       <= raw_d;
    end
  end

  assign Pending  = pend_q;
  assign Sync_Out = sync_q;

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    dead_time_gen #(
      .DEAD_W(DEAD_W)
    ) u_dt (
      .Clk     (Clk),
      .nReset  (nReset),
      .Enable  (Enable),
      .Raw     (raw_q[g]),
      .Dead    (Dead),
      .Out_High(Out_High[g]),
      .Out_Low (Out_Low[g])
    );
  end

endmodule

// File: tb/tb_pwm_centre_dt.sv
// Randomised scoreboard bench for pwm_centre_dt against a slope-queue and
// output-window reference model.
module tb_pwm_centre_dt;

  localparam int N  = 3;
  localparam int W  = 10;
  localparam int DW = 6;

  logic           Clk = 1'b0;
  logic           nReset = 1'b0;
  logic           Enable = 1'b0;
  logic           Mode = 1'b0;
  logic           Load = 1'b0;
  logic [W-1:0]   Period = '0;
  logic [DW-1:0]  Dead = '0;
  logic [N*W-1:0] Duty = '0;
  logic           Pending;
  logic [N-1:0]   Out_High;
  logic [N-1:0]   Out_Low;
  logic           Sync_Out;

  always #5 Clk = ~Clk;

  pwm_centre_dt #(
    .N         (N),
    .W         (W),
    .DEAD_W    (DW),
    .PERIOD_RST(1023)
  ) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .Enable  (Enable),
    .Mode    (Mode),
    .Period  (Period),
    .Dead    (Dead),
    .Duty    (Duty),
    .Load    (Load),
    .Pending (Pending),
    .Out_High(Out_High),
    .Out_Low (Out_Low),
    .Sync_Out(Sync_Out)
  );

  typedef struct packed {
    logic         pend;
    logic         sync;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         chk;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_out = 1'b1;

  // Reference model state: counter value, queued slope values, buffers and
  // per-cycle histories of enable and raw compare results.
  int           c = 0;
  int           slope[$];
  int           ap = 1023;
  int           pend_per = 0;
  int           a_duty[N];
  int           pend_duty[N];
  bit           pend = 1'b0;
  logic [127:0] e_hist = '0;
  logic [127:0] r_hist[N];

  function automatic int eff(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    c = 0;
    ap = 1023;
    pend = 1'b0;
    pend_per = 0;
    slope.delete();
    e_hist = '0;
    for (int j = 0; j < N; j++) begin
      a_duty[j] = 0;
      pend_duty[j] = 0;
      r_hist[j] = '0;
    end
    sb.delete();
  endtask

  task automatic model_step();
    exp_t         e;
    logic [127:0] m;
    bit           tr;
    bit           en_win;
    e = '0;
    e_hist = {e_hist[126:0], Enable};
    m = (128'd1 << (int'(Dead) + 1)) - 128'd1;
    en_win = (e_hist & m) == m;
    // A side is on only when enable and raw have both held for Dead+1 cycles.
    for (int j = 0; j < N; j++) begin
      e.hi[j] = en_win && ((r_hist[j] & m) == m);
      e.lo[j] = en_win && ((r_hist[j] & m) == '0);
      r_hist[j] = {r_hist[j][126:0], a_duty[j] > c};
    end
    e.sync = Enable && (c == 0);
    tr = pend && ((c == 0) || (Mode && (c == eff(ap))));
    if (tr) begin
      ap = pend_per;
      for (int j = 0; j < N; j++) a_duty[j] = pend_duty[j];
    end
    if (Load) begin
      pend = 1'b1;
      pend_per = int'(Period);
      for (int j = 0; j < N; j++) pend_duty[j] = int'(Duty[j*W +: W]);
    end else if (tr) begin
      pend = 1'b0;
    end
    if (!Enable) begin
      c = 0;
      slope.delete();
    end else begin
      if (slope.size() == 0) begin
        if (c == 0) for (int k = 1; k <= eff(ap); k++) slope.push_back(k);
        else for (int k = c - 1; k >= 0; k--) slope.push_back(k);
      end
      c = slope.pop_front();
    end
    e.pend = pend;
    e.chk = chk_out;
    sb.push_back(e);
  endtask

  always @(posedge Clk or negedge nReset) begin
    if (!nReset) model_reset();
    else model_step();
  end

  always @(negedge Clk) begin : mon
    exp_t e;
    if (nReset && sb.size() != 0) begin
      e = sb.pop_front();
      chk("pending", 32'(Pending), 32'(e.pend));
      chk("sync_out", 32'(Sync_Out), 32'(e.sync));
      if (e.chk) begin
        chk("out_high", 32'(Out_High), 32'(e.hi));
        chk("out_low", 32'(Out_Low), 32'(e.lo));
      end
      chk("no_overlap", 32'(Out_High & Out_Low), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic load(input int per, input int d0, input int d1, input int d2);
    Period = W'(per);
    Duty = {W'(d2), W'(d1), W'(d0)};
    Load = 1'b1;
    tick(1);
    Load = 1'b0;
  endtask

  initial begin
    int s_cnt, h0, h1, h2, l2;
    tick(3);
    nReset = 1'b1;
    repeat (5) begin
      tick(1);
      chk("idle_outs", 32'(Out_High | Out_Low | N'(Sync_Out)), 32'd0);
    end

    // Carrier shape and duty boundaries, Dead=0.
    load(4, 2, 0, 5);
    chk("pend_set", 32'(Pending), 32'd1);
    tick(1);
    chk("pend_xfer_disabled", 32'(Pending), 32'd0);
    Enable = 1'b1;
    tick(16);
    s_cnt = 0; h0 = 0; h1 = 0; h2 = 0; l2 = 0;
    repeat (32) begin
      tick(1);
      s_cnt += int'(Sync_Out);
      h0 += int'(Out_High[0]);
      h1 += int'(Out_High[1]);
      h2 += int'(Out_High[2]);
      l2 += int'(Out_Low[2]);
    end
    chk("sync_per_32", 32'(s_cnt), 32'd4);
    chk("duty2_high_12", 32'(h0), 32'd12);
    chk("duty0_never_high", 32'(h1), 32'd0);
    chk("dutymax_always_high", 32'(h2), 32'd32);
    chk("dutymax_never_low", 32'(l2), 32'd0);

    // Shadow loads, trough then peak transfer.
    tick(2);
    load(4, 1, 1, 1);
    load(4, 3, 3, 3);
    tick(12);
    Mode = 1'b1;
    tick(1);
    load(4, 1, 2, 0);
    tick(1);
    load(4, 2, 4, 1);
    tick(12);
    Mode = 1'b0;

    // Dead time with toggling duty.
    Enable = 1'b0;
    Dead = DW'(3);
    tick(2);
    Enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load(8, (i % 2) ? 2 : 6, (i % 2) ? 6 : 2, 4);
      tick(16);
    end

    // One-cycle raw pulse swallowed by Dead=3.
    Enable = 1'b0;
    load(10, 1, 1, 1);
    tick(2);
    Enable = 1'b1;
    tick(20);
    h0 = 0;
    repeat (40) begin
      tick(1);
      h0 += int'(Out_High[0]);
    end
    chk("swallowed_pulse", 32'(h0), 32'd0);

    // Random loads, modes, enable toggles; Dead only changes while disabled.
    for (int s = 0; s < 40; s++) begin
      int p;
      p = int'($urandom_range(0, 24));
      if ($urandom_range(0, 4) == 0) begin
        Enable = ~Enable;
        if (!Enable) Dead = DW'($urandom_range(0, 9));
      end
      Mode = 1'($urandom_range(0, 1));
      load(p, int'($urandom_range(0, p + 2)), int'($urandom_range(0, p + 2)),
           int'($urandom_range(0, p + 2)));
      tick(int'($urandom_range(5, 40)));
    end
    Enable = 1'b1;
    Mode = 1'b0;
    tick(4);

    // Dead changed live: only the no-overlap property is judged here.
    chk_out = 1'b0;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) Dead = DW'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) load(int'($urandom_range(2, 12)),
          int'($urandom_range(0, 14)), int'($urandom_range(0, 14)), int'($urandom_range(0, 14)));
      tick(1);
    end
    Dead = DW'(2);
    Enable = 1'b0;
    chk_out = 1'b1;
    tick(2);
    Enable = 1'b1;
    tick(30);

    // Async reset with the bridge active and a pending set.
    Enable = 1'b0;
    Dead = '0;
    load(4, 2, 2, 2);
    Enable = 1'b1;
    tick(20);
    chk("active_before_reset", 32'(|(Out_High | Out_Low)), 32'd1);
    Period = W'(6);
    Load = 1'b1;
    @(posedge Clk);
    #3;
    Load = 1'b0;
    nReset = 1'b0;
    #1;
    chk("rst_out_high", 32'(Out_High), 32'd0);
    chk("rst_out_low", 32'(Out_Low), 32'd0);
    chk("rst_pending", 32'(Pending), 32'd0);
    chk("rst_sync", 32'(Sync_Out), 32'd0);
    @(negedge Clk);
    nReset = 1'b1;
    tick(30);
    // The reset period (1023) must run a full 2046-cycle carrier before this
    // set reaches the outputs.
    load(6, 3, 1, 7);
    tick(2100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
